// File: rtl/audio_mixer_n.sv
// ============================================================================
//  Module      : audio_mixer_n
//  Description : N-channel frame mixer. On each frame strobe it snapshots all
//                channel samples, volumes, mutes and the master volume. It then
//                runs a serial multiply-accumulate, one channel per clock,
//                applies the master gain and saturates to SAMPLE_BITS. The
//                result is presented with a one-cycle valid pulse.
//  Revision    : 1.0  initial release
//
//  Optional feature macro: MIXER_RAMP_EN
//      When defined, the volume snapshot registers act as effective-volume
//      registers. On each accepted strobe they step by 1 toward their
//      target input, which de-zippers volume changes.
//
//  Ports:
//      clk            in   system clock
//      rstn           in   asynchronous active-low reset
//      sample_strobe  in   one-cycle frame tick, starts a mix
//      ch_sample      in   NUM_CH packed signed samples
//      ch_vol         in   NUM_CH packed unsigned channel gains
//      ch_mute        in   per-channel mute (1 = contributes 0)
//      master_vol     in   master gain
//      clear_flags    in   clears clip_flag / overrun_flag (a set event wins)
//      out_sample     out  mixed, saturated sample, held between frames
//      out_valid      out  one-cycle pulse when out_sample updates
//      busy           out  high while a mix is in progress
//      clip_flag      out  sticky, set when an output saturated
//      overrun_flag   out  sticky, set when a strobe arrived while busy
// ============================================================================
`default_nettype none

module audio_mixer_n #(
    parameter int NUM_CH      = 4,
    parameter int SAMPLE_BITS = 16,
    parameter int VOLUME_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          sample_strobe,
    input  logic [NUM_CH*SAMPLE_BITS-1:0] ch_sample,
    input  logic [NUM_CH*VOLUME_BITS-1:0] ch_vol,
    input  logic [NUM_CH-1:0]             ch_mute,
    input  logic [VOLUME_BITS-1:0]        master_vol,
    input  logic                          clear_flags,
    output logic [SAMPLE_BITS-1:0]        out_sample,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          clip_flag,
    output logic                          overrun_flag
);

    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Sum of NUM_CH terms, each at most SAMPLE_BITS+1 bits, cannot overflow.
    localparam int ACC_W   = SAMPLE_BITS + $clog2(NUM_CH) + 1;
    localparam int PROD_W  = SAMPLE_BITS + VOLUME_BITS + 1;
    localparam int MPROD_W = ACC_W + VOLUME_BITS + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    localparam logic signed [SAMPLE_BITS-1:0] OUT_MAX = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
    localparam logic signed [SAMPLE_BITS-1:0] OUT_MIN = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
    localparam logic signed [ACC_W:0]         SAT_MAX = (ACC_W+1)'(OUT_MAX);
    localparam logic signed [ACC_W:0]         SAT_MIN = (ACC_W+1)'(OUT_MIN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_SCALE = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]                    state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic signed [SAMPLE_BITS-1:0] samp_q [NUM_CH];
    logic signed [SAMPLE_BITS-1:0] samp_d [NUM_CH];
    logic [VOLUME_BITS-1:0]        vol_q  [NUM_CH];
    logic [VOLUME_BITS-1:0]        vol_d  [NUM_CH];
    logic [NUM_CH-1:0]             mute_q, mute_d;
    logic [VOLUME_BITS-1:0]        mvol_q, mvol_d;
    logic [SAMPLE_BITS-1:0]        out_q, out_d;
    logic                          valid_q, valid_d;
    logic                          clip_q, clip_d;
    logic                          ovr_q, ovr_d;

    // ------------------------------------------------------------------
    // Input unpacking and next volume values
    // ------------------------------------------------------------------
    logic signed [SAMPLE_BITS-1:0] w_samp_in [NUM_CH];
    logic [VOLUME_BITS-1:0]        w_vol_in  [NUM_CH];
    logic [VOLUME_BITS-1:0]        w_vol_nxt [NUM_CH];
    logic [VOLUME_BITS-1:0]        w_mvol_nxt;

`ifdef MIXER_RAMP_EN
    function automatic logic [VOLUME_BITS-1:0] step_toward(
        input logic [VOLUME_BITS-1:0] cur,
        input logic [VOLUME_BITS-1:0] tgt
    );
        if (cur < tgt)
            return cur + 1'b1;
        else if (cur > tgt)
            return cur - 1'b1;
        else
            return cur;
    endfunction
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_samp_in[gi] = ch_sample[gi*SAMPLE_BITS +: SAMPLE_BITS];
            assign w_vol_in[gi]  = ch_vol[gi*VOLUME_BITS +: VOLUME_BITS];
`ifdef MIXER_RAMP_EN
            // The snapshot register holds the effective volume and steps
            // by one toward the requested volume on every frame.
            assign w_vol_nxt[gi] = step_toward(vol_q[gi], w_vol_in[gi]);
`else
            assign w_vol_nxt[gi] = w_vol_in[gi];
`endif
        end
    endgenerate

`ifdef MIXER_RAMP_EN
    assign w_mvol_nxt = step_toward(mvol_q, master_vol);
`else
    assign w_mvol_nxt = master_vol;
`endif

    // ------------------------------------------------------------------
    // Datapath: per-channel term and master scaling
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0]      w_prod;
    logic signed [SAMPLE_BITS:0]   w_term;
    logic signed [MPROD_W-1:0]     w_mprod;
    logic signed [ACC_W:0]         w_m;
    logic                          w_sat_hi;
    logic                          w_sat_lo;
    logic [SAMPLE_BITS-1:0]        w_sat_val;
    logic                          w_unused_low;

    // Volume is zero-extended so the product is signed. Taking the upper
    // bits of the product is the arithmetic shift by VOLUME_BITS (floor).
    assign w_prod  = samp_q[idx_q] * $signed({1'b0, vol_q[idx_q]});
    assign w_term  = mute_q[idx_q] ? '0 : w_prod[PROD_W-1:VOLUME_BITS];

    assign w_mprod = acc_q * $signed({1'b0, mvol_q});
    assign w_m     = w_mprod[MPROD_W-1:VOLUME_BITS];

    // The fractional bits dropped by the shifts are intentionally discarded.
    assign w_unused_low = ^{w_prod[VOLUME_BITS-1:0], w_mprod[VOLUME_BITS-1:0]};

    assign w_sat_hi  = (w_m > SAT_MAX);
    assign w_sat_lo  = (w_m < SAT_MIN);
    assign w_sat_val = w_sat_hi ? OUT_MAX :
                       w_sat_lo ? OUT_MIN : w_m[SAMPLE_BITS-1:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        samp_d  = samp_q;
        vol_d   = vol_q;
        mute_d  = mute_q;
        mvol_d  = mvol_q;
        out_d   = out_q;
        valid_d = 1'b0;
        // Clear first so that a set event later in this block wins.
        clip_d  = clear_flags ? 1'b0 : clip_q;
        ovr_d   = clear_flags ? 1'b0 : ovr_q;

        case (state_q)
            S_IDLE: begin
                if (sample_strobe) begin
                    state_d = S_ACCUM;
                    idx_d   = '0;
                    acc_d   = '0;
                    samp_d  = w_samp_in;
                    vol_d   = w_vol_nxt;
                    mute_d  = ch_mute;
                    mvol_d  = w_mvol_nxt;
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + ACC_W'(w_term);
                if (idx_q == LAST_IDX)
                    state_d = S_SCALE;
                else
                    idx_d = idx_q + 1'b1;
            end
            S_SCALE: begin
                out_d   = w_sat_val;
                valid_d = 1'b1;
                state_d = S_IDLE;
                if (w_sat_hi || w_sat_lo)
                    clip_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes during a mix are dropped and recorded.
        if (sample_strobe && (state_q != S_IDLE))
            ovr_d = 1'b1;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            mute_q  <= '0;
            mvol_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                samp_q[i] <= '0;
                vol_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            mute_q  <= mute_d;
            mvol_q  <= mvol_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            clip_q  <= clip_d;
            ovr_q   <= ovr_d;
            for (int i = 0; i < NUM_CH; i++) begin
                samp_q[i] <= samp_d[i];
                vol_q[i]  <= vol_d[i];
            end
        end
    end

    assign out_sample   = out_q;
    assign out_valid    = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign clip_flag    = clip_q;
    assign overrun_flag = ovr_q;

endmodule

`default_nettype wire
